// File: rtl/capture_pkg.sv
// Shared types and default sizes for the sample capture engine.
package capture_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRE       = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array is not reset so it maps onto block RAM; only the read register is.
module capture_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write: a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_buffer.sv
// Circular sample capture with pre-trigger history, edge/forced trigger and a
// programmed post-trigger length; the buffer freezes in DONE for SPI readback.
module capture_buffer
  import capture_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic              force_trig,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        dbg_state
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_inc;
  logic [DATA_W-1:0] prev;
  logic              prev_valid;
  logic              we;
  logic              start;
  logic              trig_hit;
  logic              edge_hit;

  assign cnt_inc   = cnt + 1'b1;
  assign busy      = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  assign done      = (state == DONE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    we         = 1'b0;
    start      = 1'b0;
    trig_hit   = 1'b0;
    // prev_valid suppresses a false edge on the first sample of a capture.
    edge_hit   = prev_valid &&
                 (trig_rising ? ((prev <  trig_level) && (sample_data >= trig_level))
                              : ((prev >= trig_level) && (sample_data <  trig_level)));
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          start      = 1'b1;
          state_next = (pre_count == '0) ? WAIT_TRIG : PRE;
        end
      end
      PRE: begin
        if (sample_valid) begin
          we = 1'b1;
          if (cnt_inc == pre_count) state_next = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (sample_valid) begin
          we = 1'b1;
          if (force_trig || edge_hit) begin
            trig_hit   = 1'b1;
            state_next = (post_count == '0) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (sample_valid) begin
          we = 1'b1;
          if (cnt_inc == post_count) state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort outranks arm and any pending write.
    if (abort) begin
      state_next = IDLE;
      we         = 1'b0;
      start      = 1'b0;
      trig_hit   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr    <= '0;
      trig_addr  <= '0;
      cnt        <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (start) begin
      wr_addr    <= '0;
      cnt        <= '0;
      prev_valid <= 1'b0;
    end else if (we) begin
      wr_addr    <= wr_addr + 1'b1;
      prev       <= sample_data;
      prev_valid <= 1'b1;
      cnt        <= trig_hit ? '0 : cnt_inc;
      if (trig_hit) trig_addr <= wr_addr;
    end
  end

  capture_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wr_addr),
    .wdata (sample_data),
    .raddr (mem_addr),
    .rdata (mem_data)
  );

endmodule

// File: doc/capture_buffer.md
# capture_buffer

Sample capture engine that fills the 4096 x 16 memory read back over SPI through the memory-read path (`mem_addr`/`mem_data`). It records a free-running sample stream into a circular buffer with pre-trigger history and a programmed post-trigger length. It then freezes the buffer and reports completion and the trigger address for SPI status readback. Arm, abort and trigger controls are driven from SPI control-register bits.

## Interface
- `ADDR_W`, 12, buffer address width (depth 2^ADDR_W)
- `DATA_W`, 16, sample width
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `sample_valid`  in  1  qualifies `sample_data` this cycle
- `sample_data`  in  DATA_W  unsigned sample
- `arm`  in  1  single-cycle pulse, starts a capture
- `abort`  in  1  single-cycle pulse, cancels a capture
- `trig_level`  in  DATA_W  unsigned trigger threshold
- `trig_rising`  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
- `force_trig`  in  1  level; forces trigger while in WAIT_TRIG
- `pre_count`  in  ADDR_W  samples written before trigger detection is enabled
- `post_count`  in  ADDR_W  samples written after the trigger sample
- `mem_addr`  in  ADDR_W  SPI-side read address
- `mem_data`  out  DATA_W  SPI-side read data
- `busy`  out  1  capture in progress
- `done`  out  1  capture complete, buffer frozen
- `trig_addr`  out  ADDR_W  buffer address holding the trigger sample
- `wr_addr`  out  ADDR_W  next write address

## Operation
- States are IDLE, PRE, WAIT_TRIG, POST and DONE.
- **IDLE**: no writes. On `arm`: `wr_addr`<=0, counter<=0, `done`<=0, `busy`<=1. Go to PRE, or to WAIT_TRIG if `pre_count`=0.
- **PRE**: each valid sample is written at `wr_addr`; then `wr_addr`++ and counter++. When counter reaches `pre_count`, go to WAIT_TRIG.
- **WAIT_TRIG**: each valid sample is written.
  - Rising trigger: prev<`trig_level` and sample>=`trig_level`.
  - Falling trigger: prev>=`trig_level` and sample<`trig_level`.
  - `prev` is the last valid sample written in this capture. There is no edge on the first sample of a capture.
  - If `force_trig`=1, the current valid sample is the trigger.
  - On trigger: `trig_addr`<=current `wr_addr`, counter<=0, go to POST. If `post_count`=0, go to DONE instead.
- **POST**: each valid sample is written and the counter increments. After `post_count` samples, go to DONE.
- **DONE**: `busy`=0, `done`=1, no writes. `arm` starts a new capture.
- `wr_addr` wraps modulo 2^ADDR_W. Older samples are overwritten (ring). Comparisons are unsigned.
- `arm` is ignored in PRE, WAIT_TRIG and POST.
- `abort` in any state goes to IDLE with `busy`=0 and `done`=0. `wr_addr` and `trig_addr` hold their values.
- `abort` and `arm` in the same cycle: `abort` wins.
- The read port is independent of state and is always readable.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `trig_addr` 0, `wr_addr` 0, `mem_data` 0, prev-valid 0. RAM contents are not reset.
- `busy` rises the cycle after `arm`.
- A sample is written in its `sample_valid` cycle; `wr_addr` updates on the next edge.
- `trig_addr` and the state change are visible the cycle after the trigger sample.
- `done` rises the cycle after the last post-trigger sample. If `post_count`=0, it rises the cycle after the trigger sample.
- `mem_data` is registered with 1-cycle latency from `mem_addr`.
- Read and write to the same address in the same cycle: `mem_data` returns the old content.
- `rst` in any state takes effect on the next edge and forces reset values; an in-flight write in that cycle is not required to complete.

## Structure
- Package `capture_pkg` holds:
  - the state enum encoding (IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4);
  - default `ADDR_W` and `DATA_W` constants.
- Sub-module `capture_ram` is a simple dual-port RAM with a write port and a registered read port. It must infer block RAM and has no reset on the array; only the read register is reset.
- The FSM, counter, edge detector and address logic live in `capture_buffer`.

## Test plan
- **Rising trigger.** Reset, then `pre_count`=4, `post_count`=3, level 0x0100, rising. Stream 0x0000,0x0010,... (+0x10 per cycle, valid every cycle).
  - Trigger on sample 0x0100 at address 16: `trig_addr`=16.
  - `done` rises the cycle after address 19 is written; `wr_addr`=20.
  - Readback of address 16 gives 0x0100, one cycle after `mem_addr`=16.
- **Trigger inhibited in PRE.** `pre_count`=8; a crossing occurs at sample 2, stream then stays high and falls below the level at sample 20, falling mode.
  - No trigger during PRE.
  - Trigger at address 20.
- **Wrap and post_count=0.** `pre_count`=4090, `post_count`=10. Crossing at address 4094.
  - Last write goes to address 8 (wrapped); `wr_addr`=9; `trig_addr`=4094.
  - A second run with `post_count`=0 asserts `done` the cycle after the trigger sample.
- **Arm, abort and force.**
  - `arm` while busy: no effect.
  - `abort` mid-POST: `busy`=0, `done`=0, state IDLE.
  - `arm`+`abort` in the same cycle from IDLE: stays IDLE.
  - `force_trig`=1 in WAIT_TRIG with constant data 0x1234: trigger on the next valid sample.
- **Gapped valid and reset mid-capture.**
  - `sample_valid` every 3rd cycle: counters advance only on valid cycles.
  - `rst` asserted in WAIT_TRIG: next cycle all outputs at reset values, and a fresh `arm` works normally.
